snake_step_pacer: RTL

Converts the divider's slow square-wave outputs into paced, handshaken movement steps for the snake game logic. It sits directly downstream of the clock-divider block and runs entirely in the `CLKFast` domain, treating each `HZ*` signal as data, never as a clock. It selects one speed channel, turns its rising edges into step ticks, queues up to `MISS_MAX` unserved ticks, and presents them to the movement engine over a req/ack handshake.

---
 rtl/snake_pkg.sv | 20 ++
 rtl/snake_step_pacer_if.sv | 28 ++
 rtl/pacer_edge_sync.sv | 34 +++
 rtl/snake_step_pacer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake step pacer: speed channel selects, FSM states, widths.
package snake_pkg;

    localparam int unsigned PEND_W = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] SPD_1HZ  = 2'd0;
    localparam logic [1:0] SPD_2HZ  = 2'd1;
    localparam logic [1:0] SPD_5HZ  = 2'd2;
    localparam logic [1:0] SPD_40HZ = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        REQ   = 3'd2,
        GAP   = 3'd3,
        PAUSE = 3'd4
    } pacer_state_e;

endpackage

// File: rtl/snake_step_pacer_if.sv
// Pacer bus: divider square waves and game controls in, step handshake and status out.
interface snake_step_pacer_if;
    import snake_pkg::*;

    logic              HZ1;
    logic              HZ2;
    logic              HZ5;
    logic              HZ40;
    logic [1:0]        speed_sel;
    logic              run;
    logic              pause;
    logic              step_req;
    logic              step_ack;
    logic [PEND_W-1:0] pending;
    logic              overrun;
    logic [CNT_W-1:0]  tick_count;

    modport master (
        output HZ1, HZ2, HZ5, HZ40, speed_sel, run, pause, step_ack,
        input  step_req, pending, overrun, tick_count
    );

    modport slave (
        input  HZ1, HZ2, HZ5, HZ40, speed_sel, run, pause, step_ack,
        output step_req, pending, overrun, tick_count
    );

endinterface

// File: rtl/pacer_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for one divider square wave.
module pacer_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] vld_q;
    logic       rise_q;

    // prev holds 1 until s2 carries real samples, so a high input at reset release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b1;
            vld_q  <= 2'b00;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            vld_q  <= {vld_q[0], 1'b1};
            prev_q <= vld_q[1] ? s2_q : 1'b1;
            rise_q <= s2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/snake_step_pacer.sv
// Turns the selected divider channel into queued, req/ack-paced movement steps.
// Optional acked-step counter: define STEP_PACER_COUNT_EN.
module snake_step_pacer
    import snake_pkg::*;
#(
    parameter int unsigned MISS_MAX = 3
) (
    input  logic               CLKFast,
    input  logic               RST,
    snake_step_pacer_if.slave  bus
);

    localparam logic [2:0]        S_IDLE   = IDLE;
    localparam logic [2:0]        S_WAIT   = WAIT;
    localparam logic [2:0]        S_REQ    = REQ;
    localparam logic [2:0]        S_GAP    = GAP;
    localparam logic [2:0]        S_PAUSE  = PAUSE;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MISS_MAX);

    logic [3:0]        rise;
    logic [1:0]        sel_q;
    logic [1:0]        sel_prev_q;
    logic              sel_rise;
    logic              tick;
    logic              accept;
    logic              ack_ok;
    logic [2:0]        state_q,   state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              step_req_q;

    pacer_edge_sync u_sync_1hz  (.clk(CLKFast), .rst(RST), .d_i(bus.HZ1),  .rise_o(rise[0]));
    pacer_edge_sync u_sync_2hz  (.clk(CLKFast), .rst(RST), .d_i(bus.HZ2),  .rise_o(rise[1]));
    pacer_edge_sync u_sync_5hz  (.clk(CLKFast), .rst(RST), .d_i(bus.HZ5),  .rise_o(rise[2]));
    pacer_edge_sync u_sync_40hz (.clk(CLKFast), .rst(RST), .d_i(bus.HZ40), .rise_o(rise[3]));

    always_comb begin
        sel_rise = 1'b0;
        case (sel_q)
            SPD_1HZ:  sel_rise = rise[0];
            SPD_2HZ:  sel_rise = rise[1];
            SPD_5HZ:  sel_rise = rise[2];
            SPD_40HZ: sel_rise = rise[3];
        endcase
    end

    // A freshly switched channel is muted for one cycle so a switch never fakes a tick
    assign tick   = sel_rise & (sel_q == sel_prev_q);
    assign accept = tick & ((state_q == S_WAIT) | (state_q == S_REQ) | (state_q == S_GAP));
    assign ack_ok = bus.step_ack & (state_q == S_REQ);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.run)                                  state_d = S_IDLE;
                else if (bus.pause)                            state_d = S_PAUSE;
                else if ((pending_q != '0) || tick)            state_d = S_REQ;
            end
            S_REQ: begin
                if (!bus.run)          state_d = S_IDLE;
                else if (bus.step_ack) state_d = S_GAP;
            end
            S_GAP: begin
                if (!bus.run)                         state_d = S_IDLE;
                else if (bus.pause)                   state_d = S_PAUSE;
                else if ((pending_q != '0) || tick)   state_d = S_REQ;
                else                                  state_d = S_WAIT;
            end
            S_PAUSE: begin
                if (!bus.run)        state_d = S_IDLE;
                else if (!bus.pause) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept && !ack_ok) begin
            if (pending_q == PEND_MAX) overrun_d = 1'b1;
            else                       pending_d = pending_q + PEND_W'(1);
        end else if (!accept && ack_ok && (pending_q != '0)) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (state_d == S_IDLE) begin
            pending_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLKFast or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            overrun_q  <= 1'b0;
            step_req_q <= 1'b0;
            sel_q      <= SPD_1HZ;
            sel_prev_q <= SPD_1HZ;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            step_req_q <= (state_d == S_REQ);
            sel_q      <= bus.speed_sel;
            sel_prev_q <= sel_q;
        end
    end

`ifdef STEP_PACER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ack_ok) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLKFast or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.tick_count = cnt_q;
`else
    assign bus.tick_count = '0;
`endif

    assign bus.step_req = step_req_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;

endmodule
